// File: rtl/shiftout_pkg.sv
// Shared types and sizing helpers for the shiftout_tx serial transmitter.
// SHIFTOUT_PARITY_EN, when defined, appends an even-parity bit to each frame.
package shiftout_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;

`ifdef SHIFTOUT_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Bit counter must reach N (parity build) without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shiftout_piso.sv
// Parallel-load, enable-gated shift-left register; q is always the current MSB.
module shiftout_piso
    import shiftout_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         L,
    input  logic         E,
    input  logic [W-1:0] d,
    output logic         q
);

    logic [W-1:0] sr_reg;
    logic [W-1:0] shift_next;

    assign shift_next[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < W; gi++) begin : g_shift
            assign shift_next[gi] = sr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sr_reg <= '0;
        end else if (L) begin
            sr_reg <= d;
        end else if (E) begin
            sr_reg <= shift_next;
        end
    end

    assign q = sr_reg[W-1];

endmodule

// File: rtl/shiftout_tx.sv
// Valid/ready word intake, MSB-first serial transmit with one bit per E strobe.
// Optional even-parity trailer bit enabled by SHIFTOUT_PARITY_EN.
module shiftout_tx
    import shiftout_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         E,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);

    localparam int W  = N + PARITY_BITS;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    tx_state_t     state_reg;
    logic [CW-1:0] count_reg;
    logic          sout_valid_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [W-1:0]  load_word;
    logic          accept;
    logic          shift_en;
    logic          piso_q;

`ifdef SHIFTOUT_PARITY_EN
    assign load_word = {data_in, ^data_in};
`else
    assign load_word = data_in;
`endif

    assign accept   = (state_reg == IDLE) && load_valid;
    assign shift_en = (state_reg == SHIFT) && E;

    shiftout_piso #(.W(W)) u_piso (
        .Clock (Clock),
        .Reset (Reset),
        .L     (accept),
        .E     (shift_en),
        .d     (load_word),
        .q     (piso_q)
    );

    // Flags are registered alongside the state so they follow it edge for edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            sout_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        state_reg      <= SHIFT;
                        count_reg      <= '0;
                        sout_valid_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (E) begin
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST) begin
                            state_reg      <= DONE;
                            sout_valid_reg <= 1'b0;
                            done_reg       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg      <= IDLE;
                    sout_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = (state_reg == IDLE) && !Reset;
    assign sout       = sout_valid_reg & piso_q;
    assign sout_valid = sout_valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_shiftout_tx.sv
// Directed bench for shiftout_tx (N=8) with a loopback shift-left receiver.
module tb_shiftout_tx;

`ifdef SHIFTOUT_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic       E = 1'b0;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    logic [7:0] rx = 8'h00;
    int         passes = 0;
    int         fails = 0;
    int         total = 0;

    shiftout_tx #(.N(8)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .E          (E),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 Clock = ~Clock;

    // Receiver end of the link: shift-left register sampling sout on each strobe.
    always @(posedge Clock) begin
        if (E && sout_valid) rx <= {rx[6:0], sout};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one frame starting in an IDLE cycle (called at a negedge).
    // p: E asserted once every p cycles. intrude: offer 8'hFF mid-frame.
    // hold: leave load_valid high afterwards for a back-to-back frame.
    task automatic frame(input logic [7:0] w, input logic par, input int p,
                         input bit intrude, input bit hold);
        logic b;
        logic [7:0] rx_exp;
        data_in    = w;
        load_valid = 1'b1;
        E          = 1'b0;
        chk("ready_idle", {7'b0, load_ready}, 8'h01);
        @(negedge Clock);
        if (!hold) load_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            b = (i < 8) ? w[7-i] : par;
            for (int c = 0; c < p; c++) begin
                if (intrude && i == 3 && c == 0) begin
                    data_in    = 8'hFF;
                    load_valid = 1'b1;
                end
                chk($sformatf("sout_%0h_b%0d", w, i), {7'b0, sout}, {7'b0, b});
                chk("sout_valid", {7'b0, sout_valid}, 8'h01);
                chk("busy_shift", {7'b0, busy}, 8'h01);
                chk("done_shift", {7'b0, done}, 8'h00);
                chk("ready_shift", {7'b0, load_ready}, 8'h00);
                E = (c == p - 1);
                @(negedge Clock);
            end
        end
        E = 1'b0;
        if (!hold) load_valid = 1'b0;
        chk("done_pulse", {7'b0, done}, 8'h01);
        chk("busy_done", {7'b0, busy}, 8'h01);
        chk("valid_done", {7'b0, sout_valid}, 8'h00);
        chk("sout_done", {7'b0, sout}, 8'h00);
        chk("ready_done", {7'b0, load_ready}, 8'h00);
        @(negedge Clock);
        chk("done_clear", {7'b0, done}, 8'h00);
        chk("busy_clear", {7'b0, busy}, 8'h00);
        chk("ready_after", {7'b0, load_ready}, 8'h01);
`ifdef SHIFTOUT_PARITY_EN
        rx_exp = {w[6:0], par};
`else
        rx_exp = w;
`endif
        chk("rx_word", rx, rx_exp);
    endtask

    initial begin
        // Reset state
        @(negedge Clock);
        chk("rst_ready", {7'b0, load_ready}, 8'h00);
        chk("rst_sout", {7'b0, sout}, 8'h00);
        chk("rst_valid", {7'b0, sout_valid}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        Reset = 1'b0;
        @(negedge Clock);
        chk("ready_after_rst", {7'b0, load_ready}, 8'h01);

        // A5 with E held high; E in IDLE is ignored
        E = 1'b1;
        @(negedge Clock);
        chk("idle_e_ignored", {7'b0, busy}, 8'h00);
        frame(8'hA5, 1'b0, 1, 1'b0, 1'b0);

        // 3C with E every other cycle
        frame(8'h3C, 1'b0, 2, 1'b0, 1'b0);

        // A5 with a competing FF offered mid-frame
        frame(8'hA5, 1'b0, 1, 1'b1, 1'b0);

        // 07: odd parity word
        frame(8'h07, 1'b1, 1, 1'b0, 1'b0);

        // Back-to-back with load_valid held high
        frame(8'h01, 1'b1, 1, 1'b0, 1'b1);
        frame(8'h80, 1'b1, 1, 1'b0, 1'b0);

        // Asynchronous reset after 3 bits of F0
        data_in    = 8'hF0;
        load_valid = 1'b1;
        @(negedge Clock);
        load_valid = 1'b0;
        E = 1'b1;
        repeat (3) @(negedge Clock);
        chk("f0_bit3", {7'b0, sout}, 8'h01);
        #2 Reset = 1'b1;
        #1;
        chk("async_sout", {7'b0, sout}, 8'h00);
        chk("async_valid", {7'b0, sout_valid}, 8'h00);
        chk("async_busy", {7'b0, busy}, 8'h00);
        chk("async_ready", {7'b0, load_ready}, 8'h00);
        E = 1'b0;
        @(negedge Clock);
        chk("abort_no_done", {7'b0, done}, 8'h00);
        #2 Reset = 1'b0;
        @(negedge Clock);
        chk("abort_no_done2", {7'b0, done}, 8'h00);
        chk("ready_post_abort", {7'b0, load_ready}, 8'h01);
        chk("busy_post_abort", {7'b0, busy}, 8'h00);

        // Clean frame after the abort
        frame(8'hC3, 1'b0, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
